multiplier_control: RTL

Control state machine for the 8-bit signed add-shift multiplier. It sits directly upstream of the register unit: it turns the user-level `run` and `clr_ld_req` requests into the one-cycle clear, load, add, subtract and shift strobes that drive the A/B/X datapath. It reads back the current multiplier LSB `m` to decide between add, subtract and no-op on each iteration.

---
 rtl/multiplier_pkg.sv | 16 +
 rtl/multiplier_control.sv | 65 ++++++
 2 files changed

// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared state encoding and default iteration count for the add-shift multiplier
package multiplier_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_WAIT,
        CLEAR,
        ADD,
        SHIFT,
        HOLD
    } mult_state_t;

    localparam int MULT_ITERS = 8;

endpackage

// File: rtl/multiplier_control.sv
// multiplier_control: sequences clear/load/add/sub/shift strobes for the signed add-shift multiplier
module multiplier_control
    import multiplier_pkg::*;
#(
    parameter int ITERS = MULT_ITERS
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr_ld_req,
    input  logic m,
    output logic clr_ld,
    output logic clr,
    output logic add_en,
    output logic sub_en,
    output logic shift_en,
    output logic done
);

    localparam int IW = $clog2(ITERS);
    localparam logic [IW-1:0] LAST = IW'(ITERS - 1);

    mult_state_t   state, state_n;
    logic [IW-1:0] iter, iter_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            iter  <= '0;
        end else begin
            state <= state_n;
            iter  <= iter_n;
        end
    end

    // ITERS is a power of two, so the increment after the last SHIFT wraps iter to 0
    always_comb begin
        state_n = state;
        iter_n  = iter;
        case (state)
            IDLE:      state_n = clr_ld_req ? LOAD : run ? CLEAR : IDLE;
            LOAD:      state_n = LOAD_WAIT;
            LOAD_WAIT: state_n = clr_ld_req ? LOAD_WAIT : IDLE;
            CLEAR: begin
                state_n = ADD;
                iter_n  = '0;
            end
            ADD:       state_n = SHIFT;
            SHIFT: begin
                state_n = (iter == LAST) ? HOLD : ADD;
                iter_n  = iter + 1'b1;
            end
            HOLD:      state_n = run ? HOLD : IDLE;
            default:   state_n = IDLE;
        endcase
    end

    assign clr_ld   = state == LOAD;
    assign clr      = state == CLEAR;
    assign add_en   = (state == ADD) && m && (iter != LAST);
    assign sub_en   = (state == ADD) && m && (iter == LAST);
    assign shift_en = state == SHIFT;
    assign done     = state == HOLD;

endmodule
